// File: rtl/sa_anneal_scheduler.sv
// Run-level sequencer for the simulated-annealing thread controller: gates the
// pair generator, counts per-thread sweeps, steps temperature and forwards tagged pairs.
module sa_anneal_scheduler #(
    parameter int N_THREADS       = 6,
    parameter int IDX_BITS        = 3,
    parameter int CELL_BITS       = 2,
    parameter int TEMP_STEPS      = 8,
    parameter int TEMP_BITS       = 3,
    parameter int SWEEPS_PER_TEMP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [IDX_BITS-1:0]  idx_in,
    input  logic                 v_in,
    input  logic [CELL_BITS-1:0] ca_in,
    input  logic [CELL_BITS-1:0] cb_in,
    output logic                 th_rst,
    output logic                 th_start,
    output logic                 pair_valid,
    output logic [IDX_BITS-1:0]  pair_idx,
    output logic [CELL_BITS-1:0] pair_ca,
    output logic [CELL_BITS-1:0] pair_cb,
    output logic [TEMP_BITS-1:0] pair_temp,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbg_state
);

    localparam int CNT_BITS = (SWEEPS_PER_TEMP > 1) ? $clog2(SWEEPS_PER_TEMP) : 1;
    localparam logic [CNT_BITS-1:0]  CNT_LAST = CNT_BITS'(SWEEPS_PER_TEMP - 1);
    localparam logic [TEMP_BITS-1:0] TEMP_TOP = TEMP_BITS'(TEMP_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic                 acc_d;
    logic [TEMP_BITS-1:0] temp_idx;
    logic [CNT_BITS-1:0]  sweep_cnt;
    logic [N_THREADS-1:0] sweep_flags;
    logic [N_THREADS-1:0] set_mask;
    logic [N_THREADS-1:0] flags_next;
    logic                 consume;
    logic                 cells_full;
    logic                 round_done;
    logic                 last_round;

    // Handshake: no backpressure. A beat is taken when v_in is high while acc_d
    // (th_start one cycle late) is high in RUN; other beats are stale held outputs.
    assign consume    = (state == S_RUN) && acc_d && v_in && !abort;
    assign cells_full = (ca_in == '1) && (cb_in == '1);

    always_comb begin
        set_mask = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            if (consume && cells_full && (int'(idx_in) == i)) begin
                set_mask[i] = 1'b1;
            end
        end
    end

    // Completion looks at the same-cycle next flags so the last flag and the count coincide.
    assign flags_next = sweep_flags | set_mask;
    assign round_done = consume && (&flags_next);
    assign last_round = round_done && (sweep_cnt == CNT_LAST) && (temp_idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_INIT;
            S_INIT:  state_next = abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (last_round) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: state_next = abort ? S_IDLE : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        th_rst    = (state == S_INIT);
        th_start  = (state == S_RUN);
        busy      = (state == S_INIT) || (state == S_RUN) || (state == S_DRAIN);
        done      = (state == S_DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_d       <= 1'b0;
            pair_valid  <= 1'b0;
            pair_idx    <= '0;
            pair_ca     <= '0;
            pair_cb     <= '0;
            pair_temp   <= '0;
            temp_idx    <= '0;
            sweep_cnt   <= '0;
            sweep_flags <= '0;
        end else begin
            acc_d      <= th_start;
            pair_valid <= consume;
            if (consume) begin
                pair_idx  <= idx_in;
                pair_ca   <= ca_in;
                pair_cb   <= cb_in;
                pair_temp <= temp_idx;
            end
            if (state == S_INIT) begin
                temp_idx    <= TEMP_TOP;
                sweep_cnt   <= '0;
                sweep_flags <= '0;
            end else if (round_done) begin
                sweep_flags <= '0;
                if (sweep_cnt < CNT_LAST) begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                end else begin
                    sweep_cnt <= '0;
                    if (temp_idx != '0) begin
                        temp_idx <= temp_idx - 1'b1;
                    end
                end
            end else if (consume) begin
                sweep_flags <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_sa_anneal_scheduler.sv
// Bench for sa_anneal_scheduler: a short-run instance fed by a behavioural thread
// controller, plus a default instance driven with directed beats.
`timescale 1ns/1ps
module tb_sa_anneal_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;

    // short-run instance (TEMP_STEPS=2, SWEEPS_PER_TEMP=1) with controller model
    logic       a_start, a_abort, a_v;
    logic [2:0] a_idx;
    logic [1:0] a_ca, a_cb;
    logic       a_th_rst, a_th_start, a_pv, a_busy, a_done;
    logic [2:0] a_pidx, a_ptemp, a_state;
    logic [1:0] a_pca, a_pcb;

    // default-parameter instance with directed beats
    logic       d_start, d_abort, d_v;
    logic [2:0] d_idx;
    logic [1:0] d_ca, d_cb;
    logic       d_th_rst, d_th_start, d_pv, d_busy, d_done;
    logic [2:0] d_pidx, d_ptemp, d_state;
    logic [1:0] d_pca, d_pcb;

    logic [9:0] exp_q[$];

    sa_anneal_scheduler #(.TEMP_STEPS(2), .SWEEPS_PER_TEMP(1)) dut (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .idx_in(a_idx), .v_in(a_v), .ca_in(a_ca), .cb_in(a_cb),
        .th_rst(a_th_rst), .th_start(a_th_start), .pair_valid(a_pv),
        .pair_idx(a_pidx), .pair_ca(a_pca), .pair_cb(a_pcb), .pair_temp(a_ptemp),
        .busy(a_busy), .done(a_done), .dbg_state(a_state)
    );

    sa_anneal_scheduler dut_d (
        .clk(clk), .rst(rst), .start(d_start), .abort(d_abort),
        .idx_in(d_idx), .v_in(d_v), .ca_in(d_ca), .cb_in(d_cb),
        .th_rst(d_th_rst), .th_start(d_th_start), .pair_valid(d_pv),
        .pair_idx(d_pidx), .pair_ca(d_pca), .pair_cb(d_pcb), .pair_temp(d_ptemp),
        .busy(d_busy), .done(d_done), .dbg_state(d_state)
    );

    // Thread controller model: registered outputs, one valid beat every 2 enabled
    // cycles, threads round-robin, each thread walks its 16 (ca,cb) pairs in order.
    logic       m_phase;
    logic [2:0] m_thr;
    logic [3:0] m_pc [0:5];
    always @(posedge clk) begin
        if (rst || a_th_rst) begin
            m_phase <= 1'b0;
            m_thr   <= 3'd0;
            for (int i = 0; i < 6; i++) m_pc[i] <= 4'd0;
            a_v   <= 1'b0;
            a_idx <= 3'd0;
            a_ca  <= 2'd0;
            a_cb  <= 2'd0;
        end else if (a_th_start) begin
            m_phase <= ~m_phase;
            if (!m_phase) begin
                a_v        <= 1'b1;
                a_idx      <= m_thr;
                a_ca       <= m_pc[m_thr][3:2];
                a_cb       <= m_pc[m_thr][1:0];
                m_pc[m_thr] <= m_pc[m_thr] + 4'd1;
                m_thr      <= (m_thr == 3'd5) ? 3'd0 : m_thr + 3'd1;
            end else begin
                a_v <= 1'b0;
            end
        end
    end

    task automatic push_run();
        for (int t = 1; t >= 0; t--)
            for (int k = 0; k < 16; k++)
                for (int thr = 0; thr < 6; thr++)
                    exp_q.push_back({3'(t), 3'(thr), 2'(k / 4), 2'(k % 4)});
    endtask

    task automatic d_beat(input int idx, input int ca, input int cb);
        d_v   = 1'b1;
        d_idx = 3'(idx);
        d_ca  = 2'(ca);
        d_cb  = 2'(cb);
        @(posedge clk); #1;
        d_v = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        rst = 1'b1; a_start = 1'b1; d_start = 1'b1; a_abort = 1'b0; d_abort = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            outs = {a_th_rst, a_th_start, a_pv, a_pidx, a_pca, a_pcb, a_ptemp, a_busy, a_done, a_state};
            tests_run++;
            if (outs !== 18'd0) begin
                tests_failed++;
                $display("FAIL reset_a: outputs %h, expected 0", outs);
            end
            outs = {d_th_rst, d_th_start, d_pv, d_pidx, d_pca, d_pcb, d_ptemp, d_busy, d_done, d_state};
            tests_run++;
            if (outs !== 18'd0) begin
                tests_failed++;
                $display("FAIL reset_d: outputs %h, expected 0", outs);
            end
        end
        rst = 1'b0; a_start = 1'b0; d_start = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (a_state !== 3'd0 || d_state !== 3'd0 || a_th_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: states %0d/%0d th_rst %0b, expected 0/0 0", a_state, d_state, a_th_rst);
        end
    endtask

    task automatic test_stall_and_rounds();
        d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        tests_run++;
        if (d_state !== 3'd1 || d_th_rst !== 1'b1 || d_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL d_init: state %0d th_rst %0b busy %0b, expected 1 1 1", d_state, d_th_rst, d_busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (d_state !== 3'd2 || d_th_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL d_run: state %0d th_start %0b, expected 2 1", d_state, d_th_start);
        end
        // first RUN cycle: acc_d is still 0, so this held beat must be ignored
        d_v = 1'b1; d_idx = 3'd2; d_ca = 2'd3; d_cb = 2'd3;
        @(posedge clk); #1;
        d_v = 1'b0;
        tests_run++;
        if (d_pv !== 1'b0 || dut_d.sweep_flags !== 6'b000000) begin
            tests_failed++;
            $display("FAIL stall: pair_valid %0b flags %b, expected 0 000000", d_pv, dut_d.sweep_flags);
        end
        d_beat(1, 3, 2);
        tests_run++;
        if (d_pv !== 1'b1 || d_pidx !== 3'd1 || d_pca !== 2'd3 || d_pcb !== 2'd2 || d_ptemp !== 3'd7
            || dut_d.sweep_flags !== 6'b000000) begin
            tests_failed++;
            $display("FAIL partial_cells: pv %0b idx %0d ca %0d cb %0d temp %0d flags %b, expected 1 1 3 2 7 000000",
                     d_pv, d_pidx, d_pca, d_pcb, d_ptemp, dut_d.sweep_flags);
        end
        for (int i = 0; i < 5; i++) d_beat(i, 3, 3);
        tests_run++;
        if (dut_d.sweep_flags !== 6'b011111 || dut_d.sweep_cnt !== 2'd0) begin
            tests_failed++;
            $display("FAIL flags_0_4: flags %b cnt %0d, expected 011111 0", dut_d.sweep_flags, dut_d.sweep_cnt);
        end
        d_beat(6, 3, 3);
        tests_run++;
        if (d_pv !== 1'b1 || d_pidx !== 3'd6 || dut_d.sweep_flags !== 6'b011111) begin
            tests_failed++;
            $display("FAIL idx_out_of_range: pv %0b idx %0d flags %b, expected 1 6 011111", d_pv, d_pidx, dut_d.sweep_flags);
        end
        d_beat(5, 3, 3);
        tests_run++;
        if (dut_d.sweep_cnt !== 2'd1 || dut_d.sweep_flags !== 6'b000000 || d_ptemp !== 3'd7) begin
            tests_failed++;
            $display("FAIL round_complete: cnt %0d flags %b temp %0d, expected 1 000000 7", dut_d.sweep_cnt, dut_d.sweep_flags, d_ptemp);
        end
        d_beat(5, 3, 3);
        d_beat(5, 3, 3);
        tests_run++;
        if (dut_d.sweep_cnt !== 2'd1 || dut_d.sweep_flags !== 6'b100000) begin
            tests_failed++;
            $display("FAIL flag_twice: cnt %0d flags %b, expected 1 100000", dut_d.sweep_cnt, dut_d.sweep_flags);
        end
        for (int i = 0; i < 5; i++) d_beat(i, 3, 3);
        tests_run++;
        if (dut_d.sweep_cnt !== 2'd2 || dut_d.sweep_flags !== 6'b000000) begin
            tests_failed++;
            $display("FAIL round_with_preset: cnt %0d flags %b, expected 2 000000", dut_d.sweep_cnt, dut_d.sweep_flags);
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 6; i++) d_beat(i, 3, 3);
        d_beat(0, 0, 1);
        tests_run++;
        if (dut_d.sweep_cnt !== 2'd0 || d_ptemp !== 3'd6 || d_pca !== 2'd0 || d_pcb !== 2'd1) begin
            tests_failed++;
            $display("FAIL temp_step: cnt %0d temp %0d ca %0d cb %0d, expected 0 6 0 1", dut_d.sweep_cnt, d_ptemp, d_pca, d_pcb);
        end
        d_abort = 1'b1;
        @(posedge clk); #1;
        d_abort = 1'b0;
        tests_run++;
        if (d_state !== 3'd0 || d_pv !== 1'b0 || d_busy !== 1'b0 || d_done !== 1'b0 || d_th_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL d_abort: state %0d pv %0b busy %0b done %0b th_start %0b, expected 0 0 0 0 0",
                     d_state, d_pv, d_busy, d_done, d_th_start);
        end
    endtask

    task automatic test_short_run();
        int cyc, first, pairs, dones;
        logic [9:0] e;
        exp_q.delete();
        push_run();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc = 1; first = -1; pairs = 0; dones = 0;
        tests_run++;
        if (a_th_rst !== 1'b1 || a_state !== 3'd1) begin
            tests_failed++;
            $display("FAIL short_init: th_rst %0b state %0d, expected 1 1", a_th_rst, a_state);
        end
        while (dones == 0 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (a_pv) begin
                pairs++;
                if (first < 0) first = cyc;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL short_pair: extra pair %h, expected none", {a_ptemp, a_pidx, a_pca, a_pcb});
                end else begin
                    e = exp_q.pop_front();
                    if ({a_ptemp, a_pidx, a_pca, a_pcb} !== e) begin
                        tests_failed++;
                        $display("FAIL short_pair: pair %0d got %h, expected %h", pairs, {a_ptemp, a_pidx, a_pca, a_pcb}, e);
                    end
                end
            end
            if (a_done) dones++;
        end
        tests_run++;
        if (first != 4 || pairs != 192 || dones != 1 || exp_q.size() != 0 || a_busy !== 1'b0 || a_pv !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_run: first %0d pairs %0d dones %0d left %0d busy %0b pv %0b, expected 4 192 1 0 0 0",
                     first, pairs, dones, exp_q.size(), a_busy, a_pv);
        end
        @(posedge clk); #1;
        tests_run++;
        if (a_state !== 3'd0 || a_busy !== 1'b0 || a_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_idle: state %0d busy %0b done %0b, expected 0 0 0", a_state, a_busy, a_done);
        end
    endtask

    task automatic test_abort();
        int cyc, pairs, bad;
        logic [9:0] e;
        exp_q.delete();
        push_run();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cyc = 0; pairs = 0;
        while (pairs < 50 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            if (a_pv) begin
                pairs++;
                e = exp_q.pop_front();
                tests_run++;
                if ({a_ptemp, a_pidx, a_pca, a_pcb} !== e) begin
                    tests_failed++;
                    $display("FAIL abort_pair: pair %0d got %h, expected %h", pairs, {a_ptemp, a_pidx, a_pca, a_pcb}, e);
                end
            end
        end
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        tests_run++;
        if (pairs != 50 || a_state !== 3'd0 || a_pv !== 1'b0 || a_th_start !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort: pairs %0d state %0d pv %0b th_start %0b done %0b busy %0b, expected 50 0 0 0 0 0",
                     pairs, a_state, a_pv, a_th_start, a_done, a_busy);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_done || a_pv || a_state != 3'd0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL abort_quiet: %0d active cycles, expected 0", bad);
        end
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        tests_run++;
        if (a_th_rst !== 1'b1 || a_state !== 3'd1) begin
            tests_failed++;
            $display("FAIL restart_init: th_rst %0b state %0d, expected 1 1", a_th_rst, a_state);
        end
        cyc = 0;
        while (!a_pv && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests_run++;
        if (a_pv !== 1'b1 || cyc != 3 || {a_ptemp, a_pidx, a_pca, a_pcb} !== {3'd1, 3'd0, 2'd0, 2'd0}) begin
            tests_failed++;
            $display("FAIL restart_pair: pv %0b after %0d cycles pair %h, expected 1 3 %h",
                     a_pv, cyc, {a_ptemp, a_pidx, a_pca, a_pcb}, {3'd1, 3'd0, 2'd0, 2'd0});
        end
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        tests_run++;
        if (a_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL abort_again: state %0d, expected 0", a_state);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, pairs, dones, d1, init2, st_after;
        logic [9:0] e;
        exp_q.delete();
        push_run();
        push_run();
        a_start = 1'b1;
        cyc = 0; pairs = 0; dones = 0; d1 = -10; init2 = -1; st_after = -1;
        while (dones < 2 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == d1 + 1) st_after = int'(a_state);
            if (dones == 1 && init2 < 0 && a_state == 3'd1) init2 = cyc;
            if (a_pv) begin
                pairs++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_pair: extra pair %h, expected none", {a_ptemp, a_pidx, a_pca, a_pcb});
                end else begin
                    e = exp_q.pop_front();
                    if ({a_ptemp, a_pidx, a_pca, a_pcb} !== e) begin
                        tests_failed++;
                        $display("FAIL b2b_pair: pair %0d got %h, expected %h", pairs, {a_ptemp, a_pidx, a_pca, a_pcb}, e);
                    end
                end
            end
            if (a_done) begin
                dones++;
                if (dones == 1) d1 = cyc;
            end
        end
        a_start = 1'b0;
        tests_run++;
        if (dones != 2 || pairs != 384 || exp_q.size() != 0 || st_after != 0 || init2 != d1 + 2) begin
            tests_failed++;
            $display("FAIL back_to_back: dones %0d pairs %0d left %0d idle_state %0d init_at %0d, expected 2 384 0 0 %0d",
                     dones, pairs, exp_q.size(), st_after, init2, d1 + 2);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (a_state !== 3'd0 || a_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: state %0d busy %0b, expected 0 0", a_state, a_busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0;
        d_start = 1'b0; d_abort = 1'b0;
        d_v = 1'b0; d_idx = 3'd0; d_ca = 2'd0; d_cb = 2'd0;
        test_reset();
        test_stall_and_rounds();
        test_short_run();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
